seg_serial_ctrl: RTL and testbench

- Display controller for the board's serial 7-segment interface (SEGCLK/SEGCLR/SEGDT/SEGEN pads at top level).
- Accepts an 8-digit hex frame over a valid/ready handshake, encodes each digit to a segment pattern, then shifts the 64-bit frame out serially through a divided shift clock.
- Sequences the external shift register: clear after reset, enable, per-frame shifting.
- Sits between the CPU-side display register and the top-level pads.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_hex_enc.sv | 26 ++
 rtl/seg_serial_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_seg_serial_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_pkg
// Brief    : Shared types and constants for the serial 7-segment controller.
// Revision : 1.0  initial release
// ============================================================================
package seg_pkg;

    localparam int FRAME_BITS = 64;

    typedef enum logic [2:0] {
        CLEAR    = 3'd0,
        IDLE     = 3'd1,
        LOAD     = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        DONE     = 3'd5
    } state_t;

    // Segment byte {dp, g, f, e, d, c, b, a}; entry 0 is the rightmost element.
    localparam logic [15:0][7:0] c_hex_seg = {
        8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
        8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
    };

endpackage
`default_nettype wire

// File: rtl/seg_hex_enc.sv
`default_nettype none
// ============================================================================
// Module   : seg_hex_enc
// Brief    : Combinational hex-digit to segment-byte encoder with blank/dp.
// Revision : 1.0  initial release
// ============================================================================
module seg_hex_enc
    import seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] i_digit,
    input  logic       i_dp,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] w_raw;

    always_comb begin
        w_raw = i_blank ? 8'h00 : {i_dp, c_hex_seg[i_digit][6:0]};
        o_seg = ACTIVE_LOW ? ~w_raw : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/seg_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_serial_ctrl
// Brief    : Encodes an 8-digit hex frame and shifts it to the external
//            7-segment shift register (SEGCLK/SEGCLR/SEGDT/SEGEN).
// Options  : SEG_REFRESH_EN - periodic re-shift of the last captured frame.
// Revision : 1.0  initial release
// ============================================================================
module seg_serial_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int CLR_CYCLES     = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_data,
    input  logic [7:0]  upd_dp,
    input  logic [7:0]  upd_blank,
    output logic        busy,
    output logic        SEGCLK,
    output logic        SEGCLR,
    output logic        SEGDT,
    output logic        SEGEN
);

    localparam int   CLR_W     = $clog2(CLR_CYCLES + 1);
    localparam int   DIV_W     = $clog2(CLK_DIV + 1);
    localparam logic c_seg_off = (SEG_ACTIVE_LOW != 0);

    state_t                  r_state, w_state_nxt;
    logic [CLR_W-1:0]        r_clr_cnt, w_clr_cnt_nxt;
    logic [DIV_W-1:0]        r_div_cnt, w_div_cnt_nxt;
    logic [5:0]              r_bit_cnt, w_bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   r_shreg, w_shreg_nxt;
    logic [FRAME_BITS-1:0]   r_frame, w_frame_nxt;
    logic [FRAME_BITS-1:0]   w_enc_frame;
    logic                    r_segclk, w_segclk_nxt;
    logic                    r_segdt, w_segdt_nxt;
    logic                    r_segclr, w_segclr_nxt;
    logic                    r_segen, w_segen_nxt;
    logic                    r_ready, w_ready_nxt;
    logic                    w_div_end;
    logic                    w_refresh_due;

    // Digit 7 lands in the top byte so it leaves the shifter first.
    for (genvar i = 0; i < 8; i++) begin : g_enc
        seg_hex_enc #(
            .ACTIVE_LOW (SEG_ACTIVE_LOW != 0)
        ) u_enc (
            .i_digit (upd_data[4*i +: 4]),
            .i_dp    (upd_dp[i]),
            .i_blank (upd_blank[i]),
            .o_seg   (w_enc_frame[8*i +: 8])
        );
    end

`ifdef SEG_REFRESH_EN
    localparam int REF_W = $clog2(REFRESH_CYCLES + 1);
    logic [REF_W-1:0] r_ref_cnt;

    // Saturates so a period that expires mid-frame still fires once idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_cnt <= '0;
        end else if (r_state == DONE) begin
            r_ref_cnt <= '0;
        end else if (r_ref_cnt != REF_W'(REFRESH_CYCLES - 1)) begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign w_refresh_due = (r_ref_cnt == REF_W'(REFRESH_CYCLES - 1));
`else
    assign w_refresh_due = 1'b0 && (REFRESH_CYCLES > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= {FRAME_BITS{c_seg_off}};
            r_frame   <= {FRAME_BITS{c_seg_off}};
            r_segclk  <= 1'b0;
            r_segdt   <= 1'b0;
            r_segclr  <= 1'b0;
            r_segen   <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shreg   <= w_shreg_nxt;
            r_frame   <= w_frame_nxt;
            r_segclk  <= w_segclk_nxt;
            r_segdt   <= w_segdt_nxt;
            r_segclr  <= w_segclr_nxt;
            r_segen   <= w_segen_nxt;
            r_ready   <= w_ready_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shreg_nxt   = r_shreg;
        w_frame_nxt   = r_frame;
        w_segclr_nxt  = r_segclr;
        w_segen_nxt   = r_segen;
        w_div_end     = (r_div_cnt == DIV_W'(CLK_DIV - 1));

        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
                    w_state_nxt  = IDLE;
                    w_segclr_nxt = 1'b1;
                    w_segen_nxt  = 1'b1;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                // A host request wins over a coincident refresh.
                if (upd_valid && r_ready) begin
                    w_frame_nxt = w_enc_frame;
                    w_state_nxt = LOAD;
                end else if (w_refresh_due) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_shreg_nxt   = r_frame;
                w_bit_cnt_nxt = '0;
                w_div_cnt_nxt = '0;
                w_state_nxt   = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (w_div_end) begin
                    w_div_cnt_nxt = '0;
                    w_state_nxt   = SHIFT_HI;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (w_div_end) begin
                    w_div_cnt_nxt = '0;
                    w_shreg_nxt   = {r_shreg[FRAME_BITS-2:0], 1'b0};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_state_nxt   = (r_bit_cnt == 6'(FRAME_BITS - 1)) ? DONE : SHIFT_LO;
                end else begin
                    w_div_cnt_nxt = r_div_cnt + 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase

        // Pad outputs are registered from the next state so they change cleanly.
        w_ready_nxt  = (r_state == IDLE) && (w_state_nxt == IDLE);
        w_segclk_nxt = (w_state_nxt == SHIFT_HI);
        w_segdt_nxt  = ((w_state_nxt == SHIFT_LO) || (w_state_nxt == SHIFT_HI))
                       ? w_shreg_nxt[FRAME_BITS-1] : 1'b0;
    end

    assign upd_ready = r_ready;
    assign busy      = (r_state != IDLE);
    assign SEGCLK    = r_segclk;
    assign SEGDT     = r_segdt;
    assign SEGCLR    = r_segclr;
    assign SEGEN     = r_segen;

endmodule
`default_nettype wire

// File: tb/tb_seg_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_serial_ctrl
// Brief    : Scoreboard bench for seg_serial_ctrl (CLK_DIV = 2, active-low).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_serial_ctrl;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_data = '0;
    logic [7:0]  upd_dp = '0;
    logic [7:0]  upd_blank = '0;
    logic        busy;
    logic        SEGCLK, SEGCLR, SEGDT, SEGEN;

    int ntests = 0;
    int nfail  = 0;
    logic [63:0] exp_q[$];
    int mon_bits = 0;

    seg_serial_ctrl #(
        .CLK_DIV        (CLK_DIV),
        .CLR_CYCLES     (16),
        .SEG_ACTIVE_LOW (1),
        .REFRESH_CYCLES (500)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_data  (upd_data),
        .upd_dp    (upd_dp),
        .upd_blank (upd_blank),
        .busy      (busy),
        .SEGCLK    (SEGCLK),
        .SEGCLR    (SEGCLR),
        .SEGDT     (SEGDT),
        .SEGEN     (SEGEN)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Collects the bits sampled on each SEGCLK rise and checks pulse widths.
    initial begin
        logic [63:0] shbuf;
        logic [63:0] exp_frame;
        logic        prev_clk, dt_at_rise;
        int          hi_len, lo_len, bad_w;
        shbuf = '0; prev_clk = 1'b0; dt_at_rise = 1'b0;
        hi_len = 0; lo_len = 0; bad_w = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_bits = 0; prev_clk = 1'b0; hi_len = 0; lo_len = 0; bad_w = 0;
            end else begin
                if (SEGCLK && !prev_clk) begin
                    if (mon_bits > 0 && lo_len != CLK_DIV) bad_w++;
                    shbuf      = {shbuf[62:0], SEGDT};
                    dt_at_rise = SEGDT;
                    mon_bits++;
                    hi_len = 1;
                end else if (SEGCLK) begin
                    hi_len++;
                    if (SEGDT !== dt_at_rise) bad_w++;
                end else if (prev_clk) begin
                    if (hi_len != CLK_DIV) bad_w++;
                    lo_len = 1;
                    if (mon_bits == 64) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", shbuf, 64'hx);
                        end else begin
                            exp_frame = exp_q.pop_front();
                            check("frame_data", shbuf, exp_frame);
                        end
                        check("segclk_shape", 64'(bad_w), 64'd0);
                        mon_bits = 0;
                        bad_w    = 0;
                    end
                end else begin
                    lo_len++;
                end
                prev_clk = SEGCLK;
            end
        end
    end

    // Called at the negedge where rst has just been released.
    task automatic check_clear_seq();
        int n;
        n = 0;
        while (SEGCLR === 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("segclr_low_cycles", 64'(n), 64'd16);
        check("clear_exit_outputs", {60'd0, SEGCLR, SEGEN, upd_ready, busy}, {60'd0, 4'b1100});
        @(negedge clk);
        check("ready_after_clear", {63'd0, upd_ready}, 64'd1);
    endtask

    // Returns at the first negedge after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl,
                        output int waited);
        upd_data  = d;
        upd_dp    = dp;
        upd_blank = bl;
        upd_valid = 1'b1;
        waited    = 0;
        while (upd_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (upd_ready !== 1'b1) check("accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic measure_frame(input string tag);
        int  i, first, rises;
        logic prev;
        i = 0; first = -1; rises = 0; prev = 1'b0;
        while (busy === 1'b1 && i < 1000) begin
            if (SEGCLK && !prev) begin
                rises++;
                if (first < 0) first = i;
            end
            prev = SEGCLK;
            @(negedge clk);
            i++;
        end
        check({tag, "_busy_len"}, 64'(i), 64'd258);
        check({tag, "_first_rise"}, 64'(first), 64'd3);
        check({tag, "_rises"}, 64'(rises), 64'd64);
    endtask

    initial begin
        int w, r;
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, rises;
        logic prev;

        // Reset state and CLEAR sequence
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, SEGCLK, SEGDT, SEGCLR, SEGEN, upd_ready, busy},
              {58'd0, 6'b000001});
        rst = 1'b0;
        check_clear_seq();

        // Plain frame 0x01234567
        exp_q.push_back(64'hC0F9A4B0_999282F8);
        send(32'h0123_4567, 8'h00, 8'h00, w);
        measure_frame("plain");

        // Blank on digit 7, dp on digit 0
        repeat (2) @(negedge clk);
        exp_q.push_back(64'hFFF9A4B0_99928278);
        send(32'h0123_4567, 8'h01, 8'h80, w);
        measure_frame("blank_dp");

        // Backpressure: second frame held while the first shifts
        repeat (2) @(negedge clk);
        exp_q.push_back(64'hC0F9A4B0_999282F8);
        send(32'h0123_4567, 8'h00, 8'h00, w);
        exp_q.push_back(64'h80908883_C6A1868E);
        send(32'h89AB_CDEF, 8'h00, 8'h00, w);
        check("bp_wait_cycles", 64'(w), 64'd259);
        measure_frame("bp_second");

        // Reset after 30 bits of a frame that must be discarded
        repeat (2) @(negedge clk);
        send(32'hDEAD_BEEF, 8'hF0, 8'h0F, w);
        rises = 0; prev = 1'b0; w = 0;
        while (rises < 30 && w < 1000) begin
            if (SEGCLK && !prev) rises++;
            prev = SEGCLK;
            if (rises < 30) begin
                @(negedge clk);
                w++;
            end
        end
        check("reach_bit30", 64'(rises), 64'd30);
        rst = 1'b1;
        #1;
        check("midframe_reset_outputs", {58'd0, SEGCLK, SEGDT, SEGCLR, SEGEN, upd_ready, busy},
              {58'd0, 6'b000001});
        @(negedge clk);
        rst = 1'b0;
        check_clear_seq();

        // Recovery frame with mixed dp and blank
        exp_q.push_back(64'h21060821_FFFFFFFF);
        send(32'hDEAD_BEEF, 8'hF0, 8'h0F, w);
        measure_frame("after_reset");

        repeat (10) @(negedge clk);
        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        check("no_partial_bits", 64'(mon_bits), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
